param_computer: RTL and testbench
=================================

Name: param_computer

Overview:
- Parametrised successor of the team's 4-bit accumulator computer: A/B register machine with configurable data width, program/data address width and stack depth.
- Runs a two-phase fetch/execute FSM on a single clock.
- Adds valid/ready handshaked I/O, store/jump/carry-jump opcodes, non-sticky flags, and stack overflow/underflow/illegal-opcode faults.
- Top-level processing element; loaded and started by a host through a programming port.

Parameters:
- DW, 8, data width of A, B, data memory, stack entries and I/O; must be >= AW.
- AW, 4, program/data address width; program and data memories each hold 2**AW words.
- SDEPTH, 4, stack depth in entries (>= 1).

Ports:
- osc_clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse; accepted only in IDLE/HALT/FAULT.
- prog_we  in  1  program memory write strobe.
- prog_addr  in  AW  program/data memory write address.
- prog_data  in  5+AW  instruction word {op[4:0], operand[AW-1:0]}.
- dmem_we  in  1  data memory write strobe.
- dmem_wdata  in  DW  data memory write value.
- in_data  in  DW  input word.
- in_valid  in  1  input word available.
- in_ready  out  1  core waiting for input.
- out_data  out  DW  output word.
- out_valid  out  1  output word presented.
- out_ready  in  1  sink accepts output.
- busy  out  1  state is FETCH/EXEC/WAIT_IN/WAIT_OUT.
- halted  out  1  state is HALT.
- fault  out  1  state is FAULT.
- fault_code  out  2  1=stack overflow, 2=stack underflow, 3=illegal opcode; 0 otherwise.
- ip_dbg  out  AW  current IP.

Behaviour:
- Reset (async, reset=0):
  - State IDLE; IP=0; SP=0 (entry count); A=B=0; ZF=CF=0.
  - out_data=0, out_valid=0, in_ready=0, fault_code=0.
  - Memory contents are not reset.
  - Reset mid-instruction or mid-handshake aborts immediately; no partial write completes.
- Memory writes:
  - prog_we/dmem_we write at the clock edge only when not busy; ignored while busy.
  - Both may be asserted in the same cycle.
- start:
  - In IDLE/HALT/FAULT: clears IP, SP, A, B, flags and fault_code, then enters FETCH.
  - Ignored while busy.
- FETCH (1 cycle): IR <= PMEM[IP]; IP <= IP+1, wrapping modulo 2**AW; then EXEC.
- EXEC (1 cycle): executes IR and returns to FETCH unless stated otherwise. Nominal instruction cost is 2 cycles.
- Flags:
  - Flag-writing ops set ZF = (result == 0); ZF is not sticky. This applies to ADD, SUB, INC, XCHG (on new B), IN, LD, LDI, POP, RCL (on B) and AND.
  - CF is written only by ADD (carry out), SUB (borrow, i.e. A<B), INC (carry out) and RCL.
  - All other ops leave both flags unchanged.
- Opcodes (op[4:0]); operand is zero-extended to DW where used as data:
  - 00 ADD A+=B; 01 SUB A-=B; 02 XCHG A<->B.
  - 03 IN A: go to WAIT_IN.
  - 04 OUT A: out_data<=A, out_valid<=1, go to WAIT_OUT.
  - 05 INC A; 06 LD A=DMEM[opnd]; 07 LDI A=opnd.
  - 08 JZ opnd; 09 PUSH B; 0A POP B.
  - 0B RCL B: {CF,B} <= {B,CF}.
  - 0C CALL opnd: push return IP, jump. 0D RET.
  - 0E AND A&=DMEM[opnd]; 0F HLT.
  - 10 ST DMEM[opnd]=A; 11 JC opnd; 12 JMP opnd; 13 NOP.
  - 14-1F illegal.
- WAIT_IN:
  - in_ready=1.
  - At the edge where in_valid&&in_ready: A<=in_data, ZF updated, in_ready<=0, go to FETCH.
  - Holds indefinitely otherwise.
- WAIT_OUT:
  - out_valid held with out_data stable until the edge where out_ready=1; then out_valid<=0, go to FETCH.
  - out_data retains its last value afterwards.
- Stack:
  - Entries are DW wide; return addresses are zero-extended from AW.
  - PUSH/CALL with SP==SDEPTH: no write, no jump, FAULT with code 1.
  - POP/RET with SP==0: B and IP unchanged, FAULT with code 2.
- Illegal opcode: FAULT with code 3; A, B and flags unchanged.
- HLT: go to HALT. HALT and FAULT are terminal until start or reset.
- Jumps: the target replaces the already-incremented IP. Jump to own address is legal (spin loop).

Test Plan:
- Arithmetic: load LDI 5; XCHG; LDI 3; ADD; OUT; HLT, start, out_ready=1 -> out_data=0x08, out_valid high for exactly 1 cycle, then halted=1 with CF=0, ZF=0, B=5.
- Carry and non-sticky ZF: A=0xFF via IN, INC -> A=0x00, CF=1, ZF=1; following LDI 1 -> ZF=0; JC 9 is taken and JZ is not.
- Handshake stall: IN with in_valid low for 10 cycles -> in_ready stays 1 and IP frozen; in_valid=1 with 0x5A -> A=0x5A. OUT with out_ready low for 7 cycles -> out_valid and out_data stay stable.
- Stack: SDEPTH=4, five PUSHes -> fault=1, fault_code=1, SP=4. Restart, then POP on empty stack -> fault_code=2. CALL 8 / RET pair -> execution resumes at call address+1.
- Illegal and control: opcode 0x1F -> fault_code=3. prog_we while busy -> PMEM unchanged. start while busy -> ignored. Reset asserted during WAIT_OUT -> out_valid=0 immediately (asynchronous), state IDLE.
- Memory: ST 3 then LD 3 after LDI 0 -> A restored to the stored value. AND A,[addr] with DMEM=0x0F and A=0xF0 -> A=0, ZF=1.

Source files
------------

// File: rtl/param_computer.sv
// param_computer: parametrised A/B register machine with fetch/execute FSM, stack and handshaked I/O
// Ports: osc_clock/reset (async, active-low); start, prog_we/prog_addr/prog_data and
// dmem_we/dmem_wdata form the host programming port; in_* and out_* are valid/ready
// streams; busy/halted/fault/fault_code/ip_dbg report status.
module param_computer #(
  parameter int DW = 8,
  parameter int AW = 4,
  parameter int SDEPTH = 4
) (
  input  logic          osc_clock,
  input  logic          reset,
  input  logic          start,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [AW+4:0] prog_data,
  input  logic          dmem_we,
  input  logic [DW-1:0] dmem_wdata,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          halted,
  output logic          fault,
  output logic [1:0]    fault_code,
  output logic [AW-1:0] ip_dbg
);
  localparam int SPW = $clog2(SDEPTH + 1);
  localparam int SIW = SDEPTH > 1 ? $clog2(SDEPTH) : 1;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT_IN, WAIT_OUT, HALT, FAULT} state_t;
  state_t state;
  logic [AW+4:0] pmem [2**AW];
  logic [DW-1:0] dmem [2**AW];
  logic [DW-1:0] stk [SDEPTH];
  logic [AW+4:0] ir;
  logic [AW-1:0] ip, opnd;
  logic [DW-1:0] a, b, opx, mval, top, sum, dif, inc, rcl;
  logic [SPW-1:0] sp, spm1;
  logic [4:0] op;
  logic zf, cf, sum_c, inc_c, full, empty;
  always_comb begin
    op = ir[AW+4:AW];
    opnd = ir[AW-1:0];
    opx = DW'(opnd);
    mval = dmem[opnd];
    spm1 = sp - 1'b1;
    top = stk[spm1[SIW-1:0]];
    {sum_c, sum} = {1'b0, a} + {1'b0, b};
    {inc_c, inc} = {1'b0, a} + 1'b1;
    dif = a - b;
    rcl = DW'({b, cf});
    full = sp == SPW'(SDEPTH);
    empty = sp == '0;
    busy = state inside {FETCH, EXEC, WAIT_IN, WAIT_OUT};
    halted = state == HALT;
    fault = state == FAULT;
    ip_dbg = ip;
  end
  // Memories carry no reset; core-side writes are gated by reset so an abort never commits.
  always_ff @(posedge osc_clock) begin
    if (!busy && prog_we) pmem[prog_addr] <= prog_data;
    if (!busy && dmem_we) dmem[prog_addr] <= dmem_wdata;
    else if (reset && state == EXEC && op == 5'h10) dmem[opnd] <= a;
    if (reset && state == EXEC && !full && (op == 5'h09 || op == 5'h0C))
      stk[sp[SIW-1:0]] <= op == 5'h09 ? b : DW'(ip);
  end
  always_ff @(posedge osc_clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ip <= '0;
      sp <= '0;
      a <= '0;
      b <= '0;
      zf <= 1'b0;
      cf <= 1'b0;
      ir <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      in_ready <= 1'b0;
      fault_code <= 2'd0;
    end else begin
      case (state)
        FETCH: begin
          ir <= pmem[ip];
          ip <= ip + 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          case (op)
            5'h00: begin {cf, a} <= {sum_c, sum}; zf <= sum == '0; end
            5'h01: begin a <= dif; cf <= a < b; zf <= dif == '0; end
            5'h02: begin a <= b; b <= a; zf <= a == '0; end
            5'h03: begin in_ready <= 1'b1; state <= WAIT_IN; end
            5'h04: begin out_data <= a; out_valid <= 1'b1; state <= WAIT_OUT; end
            5'h05: begin {cf, a} <= {inc_c, inc}; zf <= inc == '0; end
            5'h06: begin a <= mval; zf <= mval == '0; end
            5'h07: begin a <= opx; zf <= opnd == '0; end
            5'h08: if (zf) ip <= opnd;
            5'h09: if (full) begin state <= FAULT; fault_code <= 2'd1; end else sp <= sp + 1'b1;
            5'h0A: if (empty) begin state <= FAULT; fault_code <= 2'd2; end
                   else begin b <= top; sp <= spm1; zf <= top == '0; end
            5'h0B: begin cf <= b[DW-1]; b <= rcl; zf <= rcl == '0; end
            5'h0C: if (full) begin state <= FAULT; fault_code <= 2'd1; end
                   else begin sp <= sp + 1'b1; ip <= opnd; end
            5'h0D: if (empty) begin state <= FAULT; fault_code <= 2'd2; end
                   else begin ip <= top[AW-1:0]; sp <= spm1; end
            5'h0E: begin a <= a & mval; zf <= (a & mval) == '0; end
            5'h0F: state <= HALT;
            5'h10, 5'h13: ;
            5'h11: if (cf) ip <= opnd;
            5'h12: ip <= opnd;
            default: begin state <= FAULT; fault_code <= 2'd3; end
          endcase
        end
        WAIT_IN: if (in_valid) begin
          a <= in_data;
          zf <= in_data == '0;
          in_ready <= 1'b0;
          state <= FETCH;
        end
        WAIT_OUT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= FETCH;
        end
        default: if (start) begin
          ip <= '0;
          sp <= '0;
          a <= '0;
          b <= '0;
          zf <= 1'b0;
          cf <= 1'b0;
          fault_code <= 2'd0;
          state <= FETCH;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_param_computer.sv
// tb_param_computer: scoreboard bench with an instruction-level reference model
module tb_param_computer;
  localparam int DW = 8, AW = 4, SD = 4, N = 16;
  logic osc_clock = 0, reset = 0, start = 0, prog_we = 0, dmem_we = 0, in_valid = 0, out_ready = 0;
  logic [AW-1:0] prog_addr = '0;
  logic [AW+4:0] prog_data = '0;
  logic [DW-1:0] dmem_wdata = '0, in_data = '0;
  logic in_ready, out_valid, busy, halted, fault;
  logic [DW-1:0] out_data;
  logic [1:0] fault_code;
  logic [AW-1:0] ip_dbg;
  int checks = 0, errors = 0;
  int mp[N], md[N];
  int pre[$], sb[$], in_q[$], m_out[$], m_in[$];
  int exp_halt, exp_code, exp_ip, in_stall = 0, out_stall = 0, stall_ip, held_data;
  bit prev_hs = 0, stalling = 0, held = 0;

  param_computer #(.DW(DW), .AW(AW), .SDEPTH(SD)) dut (
    .osc_clock(osc_clock), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .halted(halted),
    .fault(fault), .fault_code(fault_code), .ip_dbg(ip_dbg));

  always #5 osc_clock = ~osc_clock;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic int ins(input int op, input int o);
    return op * 16 + o;
  endfunction

  // ISA-level interpreter: runs the program to HLT or a fault, recording I/O traffic
  task automatic model(output bit ok);
    int a = 0, b = 0, z = 0, c = 0, ip = 0, op, o, r;
    int d[N];
    int st[$];
    d = md;
    m_out.delete();
    m_in.delete();
    ok = 0;
    exp_halt = 0;
    exp_code = 0;
    repeat (120) begin
      op = mp[ip] / 16;
      o = mp[ip] % 16;
      ip = (ip + 1) % N;
      case (op)
        0: begin r = a + b; c = r > 255; a = r % 256; z = a == 0; end
        1: begin c = a < b; a = (a - b + 256) % 256; z = a == 0; end
        2: begin r = a; a = b; b = r; z = b == 0; end
        3: begin
          r = pre.size() > 0 ? pre.pop_front() : ($urandom % 4 == 0 ? 0 : $urandom % 256);
          m_in.push_back(r);
          a = r;
          z = a == 0;
        end
        4: m_out.push_back(a);
        5: begin r = a + 1; c = r > 255; a = r % 256; z = a == 0; end
        6: begin a = d[o]; z = a == 0; end
        7: begin a = o; z = a == 0; end
        8: if (z) ip = o;
        9: if (st.size() == SD) exp_code = 1; else st.push_back(b);
        10: if (st.size() == 0) exp_code = 2; else begin b = st.pop_back(); z = b == 0; end
        11: begin r = b; b = (b * 2 + c) % 256; c = r / 128; z = b == 0; end
        12: if (st.size() == SD) exp_code = 1; else begin st.push_back(ip); ip = o; end
        13: if (st.size() == 0) exp_code = 2; else ip = st.pop_back();
        14: begin a = a & d[o]; z = a == 0; end
        15: exp_halt = 1;
        16: d[o] = a;
        17: if (c) ip = o;
        18: ip = o;
        19: ;
        default: exp_code = 3;
      endcase
      if (exp_halt != 0 || exp_code != 0) begin
        ok = 1;
        exp_ip = ip;
        return;
      end
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < N; i++) begin
      mp[i] = ins(15, 0);
      md[i] = $urandom % 256;
    end
  endtask

  task automatic launch();
    for (int i = 0; i < N; i++) begin
      @(negedge osc_clock);
      prog_we = 1;
      dmem_we = 1;
      prog_addr = i[AW-1:0];
      prog_data = mp[i][AW+4:0];
      dmem_wdata = md[i][DW-1:0];
    end
    @(negedge osc_clock);
    prog_we = 0;
    dmem_we = 0;
    foreach (m_out[i]) sb.push_back(m_out[i]);
    foreach (m_in[i]) in_q.push_back(m_in[i]);
    start = 1;
    @(negedge osc_clock);
    start = 0;
  endtask

  task automatic finish_run(input string name);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge osc_clock);
      n++;
    end
    chk({name, " busy"}, busy, 0);
    chk({name, " halted"}, halted, exp_halt);
    chk({name, " fault_code"}, fault_code, exp_code);
    chk({name, " fault"}, fault, exp_code != 0);
    chk({name, " ip"}, ip_dbg, exp_ip);
    chk({name, " outs left"}, sb.size(), 0);
    chk({name, " ins left"}, in_q.size(), 0);
    sb.delete();
    in_q.delete();
  endtask

  task automatic run(input string name);
    bit ok;
    model(ok);
    launch();
    finish_run(name);
  endtask

  always @(negedge osc_clock) begin
    if (prev_hs && in_q.size() > 0) in_q.delete(0);
    if (in_stall > 0 && (in_ready || stalling)) begin
      if (!stalling) begin
        stalling = 1;
        stall_ip = ip_dbg;
      end else begin
        chk("stall in_ready", in_ready, 1);
        chk("stall ip", ip_dbg, stall_ip);
      end
      in_stall--;
      if (in_stall == 0) stalling = 0;
      in_valid = 0;
    end else in_valid = (in_q.size() > 0) && ($urandom % 2 == 1);
    in_data = in_q.size() > 0 ? in_q[0][DW-1:0] : DW'($urandom);
    prev_hs = in_valid && in_ready;
  end

  always @(negedge osc_clock) begin
    if (out_valid) begin
      if (held) chk("out stable", out_data, held_data);
      if (out_stall > 0) begin
        out_stall--;
        out_ready = 0;
      end else out_ready = $urandom % 3 != 0;
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected out got %0h want none", out_data);
        end else chk("out data", out_data, sb.pop_front());
      end
      held = !out_ready;
      held_data = out_data;
    end else begin
      if (held && reset) chk("out held", out_valid, 1);
      held = 0;
      out_ready = $urandom % 2;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    repeat (3) @(negedge osc_clock);
    chk("rst busy", busy, 0);
    chk("rst halted", halted, 0);
    chk("rst fault", fault, 0);
    chk("rst fault_code", fault_code, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst in_ready", in_ready, 0);
    chk("rst ip", ip_dbg, 0);
    reset = 1;

    clear_prog();
    mp[0] = ins(7, 5); mp[1] = ins(2, 0); mp[2] = ins(7, 3); mp[3] = ins(0, 0);
    mp[4] = ins(4, 0); mp[5] = ins(17, 15); mp[6] = ins(8, 15); mp[7] = ins(2, 0);
    mp[8] = ins(4, 0); mp[15] = ins(4, 0);
    run("arith");

    clear_prog();
    pre = '{255};
    mp[0] = ins(3, 0); mp[1] = ins(5, 0); mp[2] = ins(8, 4); mp[4] = ins(4, 0);
    mp[5] = ins(7, 1); mp[6] = ins(8, 14); mp[7] = ins(17, 9); mp[9] = ins(4, 0);
    mp[14] = ins(4, 0);
    run("carry");

    clear_prog();
    pre = '{8'h5A};
    mp[0] = ins(3, 0); mp[1] = ins(4, 0);
    in_stall = 10;
    out_stall = 7;
    run("stall");

    clear_prog();
    for (int i = 0; i < 5; i++) mp[i] = ins(9, 0);
    run("overflow");

    clear_prog();
    mp[0] = ins(10, 0);
    run("underflow");

    clear_prog();
    mp[0] = ins(12, 8); mp[1] = ins(4, 0); mp[8] = ins(7, 9); mp[9] = ins(13, 0);
    run("callret");

    clear_prog();
    mp[0] = ins(7, 4); mp[1] = ins(31, 0);
    run("illegal");

    clear_prog();
    mp[0] = ins(7, 12); mp[1] = ins(16, 3); mp[2] = ins(7, 0); mp[3] = ins(6, 3); mp[4] = ins(4, 0);
    run("st_ld");

    clear_prog();
    pre = '{8'hF0};
    md[5] = 8'h0F;
    mp[0] = ins(3, 0); mp[1] = ins(14, 5); mp[2] = ins(8, 4); mp[4] = ins(4, 0);
    run("and");

    clear_prog();
    pre = '{8'h33};
    mp[0] = ins(3, 0); mp[1] = ins(4, 0);
    in_stall = 6;
    model(ok);
    launch();
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge osc_clock);
      n++;
    end
    chk("poke wait in_ready", in_ready, 1);
    prog_we = 1;
    prog_addr = 1;
    prog_data = 9'h0F0;
    start = 1;
    @(negedge osc_clock);
    prog_we = 0;
    start = 0;
    finish_run("busy_poke");

    clear_prog();
    mp[0] = ins(7, 7); mp[1] = ins(4, 0);
    out_stall = 1000;
    model(ok);
    launch();
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge osc_clock);
      n++;
    end
    chk("pre-reset out_valid", out_valid, 1);
    #2 reset = 0;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst busy", busy, 0);
    chk("async rst halted", halted, 0);
    chk("async rst out_data", out_data, 0);
    chk("async rst ip", ip_dbg, 0);
    out_stall = 0;
    sb.delete();
    @(negedge osc_clock);
    held = 0;
    reset = 1;

    repeat (30) begin
      int tries = 0;
      do begin
        for (int i = 0; i < N; i++) begin
          int op = $urandom % 21;
          mp[i] = op == 20 ? ins(20 + $urandom % 12, $urandom % 16) : ins(op, $urandom % 16);
          md[i] = $urandom % 256;
        end
        model(ok);
        tries++;
      end while (!ok && tries < 50);
      if (ok) begin
        launch();
        finish_run("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
